// File: rtl/decoder.sv
// OPPM packet decoder: locks on a preamble, slices each data frame into one
// N_MOD-bit symbol and publishes the assembled payload with an avail flag.
module decoder #(
  parameter int unsigned PULSE_CT = 2,
  parameter int unsigned N_MOD    = 2,
  parameter int unsigned L        = 4,
  parameter int unsigned N_PKT    = 8,
  parameter int unsigned PRE_CT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             read,
  output logic [N_PKT-1:0] data,
  output logic             avail
);

  localparam int unsigned SLOTS   = 2 ** N_MOD;
  localparam int unsigned FRAME   = L * SLOTS;
  localparam int unsigned DATA_CT = N_PKT / N_MOD;
  localparam int unsigned OFF_W   = $clog2(FRAME);
  localparam int unsigned FR_MAX  = (PRE_CT > DATA_CT) ? PRE_CT : DATA_CT;
  localparam int unsigned FR_W    = $clog2(FR_MAX + 1);

  localparam logic [OFF_W-1:0] L_W       = OFF_W'(L);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(FRAME - 1);
  localparam logic [FR_W-1:0]  PRE_LAST  = FR_W'(PRE_CT - 1);
  localparam logic [FR_W-1:0]  DATA_LAST = FR_W'(DATA_CT - 1);

  generate
    if (PULSE_CT < 1 || PULSE_CT >= L) begin : g_bad_pulse
      $error("decoder: PULSE_CT must be in 1..L-1");
    end
    if ((N_PKT % N_MOD) != 0 || N_PKT <= N_MOD) begin : g_bad_pkt
      $error("decoder: N_PKT must be a multiple of N_MOD and larger than it");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t           state;
  logic             prev;
  logic             armed;
  logic             seen;
  logic [OFF_W-1:0] offset;
  logic [FR_W-1:0]  frame;
  logic [N_PKT-1:0] shreg;

  logic             rise;
  logic             in_slot0;
  logic             frame_end;
  logic [N_MOD-1:0] sym;
  logic [N_PKT-1:0] shift_nxt;

  // armed blocks a false edge when pulse is already high as reset releases
  assign rise      = pulse & ~prev & armed;
  assign in_slot0  = offset < L_W;
  assign frame_end = offset == OFF_LAST;
  assign sym       = N_MOD'(offset / L_W);
  assign shift_nxt = N_PKT'({shreg, sym});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      prev   <= 1'b0;
      armed  <= 1'b0;
      seen   <= 1'b0;
      offset <= '0;
      frame  <= '0;
      shreg  <= '0;
      data   <= '0;
      avail  <= 1'b0;
    end else begin
      prev <= pulse;
      if (!pulse) armed <= 1'b1;
      if (avail && read) avail <= 1'b0;

      if (state != IDLE) offset <= frame_end ? '0 : offset + OFF_W'(1);

      case (state)
        IDLE: begin
          if (rise) begin
            state  <= PREAMBLE;
            offset <= OFF_W'(1);
            frame  <= '0;
            seen   <= 1'b1;
            shreg  <= '0;
          end
        end

        PREAMBLE: begin
          // frame 0 starts with seen set, so only frames 1.. are policed
          if (rise && !seen) begin
            if (in_slot0) seen <= 1'b1;
            else          state <= IDLE;
          end
          if (frame_end) begin
            seen <= 1'b0;
            if (!seen) begin
              state <= IDLE;
            end else if (frame == PRE_LAST) begin
              state <= DATA;
              frame <= '0;
            end else begin
              frame <= frame + FR_W'(1);
            end
          end
        end

        DATA: begin
          if (rise && !seen) begin
            seen  <= 1'b1;
            shreg <= shift_nxt;
            if (frame == DATA_LAST) begin
              data  <= shift_nxt;
              avail <= 1'b1;
              state <= IDLE;
            end
          end
          if (frame_end) begin
            seen  <= 1'b0;
            frame <= frame + FR_W'(1);
            if (!seen && !rise) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder at default parameters (L=4, 4 slots, 8-bit payload).
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       read;
  logic [7:0] data;
  logic       avail;

  int total = 0;
  int bad   = 0;
  logic lp, la;

  always #5 clk = ~clk;

  decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (pulse),
    .read  (read),
    .data  (data),
    .avail (avail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nfr frames of a packet carrying v; frame skip_f gets no pulse,
  // preamble frame 1 puts its edge at pre1_off. Samples avail around the last edge.
  task automatic send(input logic [7:0] v, input int nfr, input int skip_f,
                      input int pre1_off, input bit rd_end,
                      output logic lat_pre, output logic lat_post);
    lat_pre  = 1'b0;
    lat_post = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      int e;
      int b;
      bit last;
      if (f < 3) begin
        e = (f == 1) ? pre1_off : 0;
      end else begin
        b = 7 - 2 * (f - 3);
        e = int'(v[b -: 2]) * 4;
      end
      last = (f == 6);
      for (int off = 0; off < 16; off++) begin
        pulse = (f != skip_f) && (off >= e) && (off < e + 2);
        if (last && off == e) begin
          lat_pre = avail;
          read    = rd_end;
        end
        tick();
        if (last && off == e) begin
          lat_post = avail;
          read     = 1'b0;
        end
      end
    end
    pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    pulse = 1'b0;
    read  = 1'b0;
    #2;
    check("reset_data", 32'(data), 32'h0);
    check("reset_avail", 32'(avail), 32'h0);
    tick();
    rst_n = 1'b0;
    tick();

    // basic packet with completion latency
    send(8'hB4, 7, -1, 0, 1'b0, lp, la);
    check("b4_avail_before", 32'(lp), 32'h0);
    check("b4_avail_after", 32'(la), 32'h1);
    check("b4_data", 32'(data), 32'hB4);

    read = 1'b1; tick(); read = 1'b0;
    check("read_clears_avail", 32'(avail), 32'h0);
    check("read_keeps_data", 32'(data), 32'hB4);

    read = 1'b1; tick(); read = 1'b0; tick();
    check("read_idle_avail", 32'(avail), 32'h0);
    check("read_idle_data", 32'(data), 32'hB4);

    // back-to-back packets without read
    send(8'h1E, 7, -1, 0, 1'b0, lp, la);
    check("1e_data", 32'(data), 32'h1E);
    repeat (16) tick();
    send(8'hC3, 7, -1, 0, 1'b0, lp, la);
    check("c3_data", 32'(data), 32'hC3);
    check("c3_avail", 32'(avail), 32'h1);
    repeat (16) tick();

    // completion beats a simultaneous read
    send(8'h77, 7, -1, 0, 1'b1, lp, la);
    check("77_avail", 32'(la), 32'h1);
    check("77_data", 32'(data), 32'h77);
    tick();
    check("77_avail_hold", 32'(avail), 32'h1);

    rst_n = 1'b1; #1;
    check("rst2_data", 32'(data), 32'h0);
    check("rst2_avail", 32'(avail), 32'h0);
    tick(); rst_n = 1'b0; tick();

    // missing pulse in data frame 2 aborts
    send(8'hFF, 6, 5, 0, 1'b0, lp, la);
    repeat (4) tick();
    check("abort_avail", 32'(avail), 32'h0);
    check("abort_data", 32'(data), 32'h0);
    send(8'h5A, 7, -1, 0, 1'b0, lp, la);
    check("5a_data", 32'(data), 32'h5A);
    check("5a_avail", 32'(avail), 32'h1);

    // preamble edge outside slot 0 aborts; the leftover frames never complete
    send(8'h00, 7, -1, 8, 1'b0, lp, la);
    repeat (40) tick();
    check("pre_abort_data", 32'(data), 32'h5A);
    check("pre_abort_avail", 32'(avail), 32'h1);

    // reset during preamble frame 1 with pulse held high across release
    repeat (20) tick();
    send(8'h0F, 1, -1, 0, 1'b0, lp, la);
    pulse = 1'b1; tick();
    rst_n = 1'b1; #1;
    check("rst3_data", 32'(data), 32'h0);
    check("rst3_avail", 32'(avail), 32'h0);
    tick(); tick();
    rst_n = 1'b0;
    repeat (3) tick();
    pulse = 1'b0;
    repeat (5) tick();
    send(8'h0F, 7, -1, 0, 1'b0, lp, la);
    check("0f_data", 32'(data), 32'h0F);
    check("0f_avail", 32'(avail), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
